shift_reg_sequencer: RTL and testbench
======================================

// Module: shift_reg_sequencer
// PURPOSE
//  Multi-cycle controller for register-specified shifts (shift_operand[4]=1, amount = Rs[7:0]).
//  Latches Rm, the shift type and the Rs amount, then iterates a small per-cycle shifter.
//  It produces the ARM-correct Val2 and the shifter carry-out, and holds the pipeline stall meanwhile.
//  Sits beside the Val2 generator in EXE; its result muxes onto val2 when the op is register-shifted.
// PARAMETERS
//  DATA_W  32  operand width; only 32 is supported
//  STEP    8   maximum bit positions shifted per SHIFT cycle (power of two, 1..16)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous reset, active-high
//  start       in   1       request; sampled only in IDLE
//  shift_type  in   2       00 LSL, 01 LSR, 10 ASR, 11 ROR
//  val_rm      in   DATA_W  operand to shift
//  rs_amount   in   8       shift amount, Rs[7:0]
//  carry_in    in   1       CPSR C, passed through when the effective amount is 0
//  flush       in   1       pipeline flush; aborts the operation in flight
//  busy        out  1       high while in state SHIFT or DONE
//  stall       out  1       combinational: busy | (start & state==IDLE)
//  done        out  1       one-cycle pulse; result/carry_out are valid
//  result      out  DATA_W  shifted value, registered, held until the next accepted start
//  carry_out   out  1       last bit shifted out, registered, held likewise
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, result, carry_out = 0. Reset mid-operation discards all work; done does not pulse.
//  - FSM states: IDLE, SHIFT, DONE.
//  - Accept: when start=1 in IDLE, latch val_rm, type, carry_in and compute rem.
//  - rem for LSL/LSR: min(rs_amount, 33). 33 shifts give result 0 and carry 0.
//  - rem for ASR: min(rs_amount, 32).
//  - rem for ROR: rs_amount[4:0]. If rs_amount != 0 and rs_amount[4:0] = 0, go straight to DONE with
//    result = val_rm and carry_out = val_rm[31].
//  - rs_amount = 0 (any type): go straight to DONE with result = val_rm and carry_out = carry_in.
//  - SHIFT: each cycle shift by k = min(rem, STEP) and set rem -= k. Carry = last bit shifted out:
//    LSL bit[32-k], LSR/ASR/ROR bit[k-1]. ASR fills with the sign bit; ROR wraps.
//    When rem reaches 0, go to DONE.
//  - DONE: done=1 for exactly one cycle, then go to IDLE. A start in that same cycle is ignored.
//  - Latency (start cycle to done): 1 cycle for the direct paths; otherwise ceil(rem/STEP)+1.
//    Maximum with STEP=8 is 6 (LSL/LSR amount >= 33).
//  - start outside IDLE is ignored; the requester keeps start high while stall=1.
//  - flush (any state except IDLE): next state IDLE; done is suppressed; result and carry_out keep
//    their old values. flush has priority over a DONE transition in the same cycle.
//  - start and flush both high in IDLE: flush wins and nothing is accepted.
// STRUCTURE
//  - Shared package (arm_defs): shift-type constants SH_LSL/SH_LSR/SH_ASR/SH_ROR and the FSM
//    state encoding (S_IDLE/S_SHIFT/S_DONE). The Val2 generator and the decode stage use the same
//    shift-type constants.
//  - Sub-module shift_step: combinational single-step shifter.
//    Inputs: value, type, k in 0..STEP. Outputs: shifted value, carry bit.
//  - This module keeps the FSM, the rem counter, the operand and carry registers, and the stall logic.
// TESTING
//  1. LSL 0x0000_0001 by 4, carry_in=1 -> result 0x0000_0010, carry_out 0; done 2 cycles after start.
//  2. LSR 0x8000_0000 by 32 -> result 0x0000_0000, carry_out 1; done at cycle 5.
//     LSL 0xFFFF_FFFF by 40 -> result 0, carry_out 0; done at cycle 6.
//  3. ASR 0x8000_0000 by 200 -> result 0xFFFF_FFFF, carry_out 1; done at cycle 5.
//     ROR 0x0000_00F0 by 36 -> result 0x0000_000F, carry_out 0; done at cycle 2.
//  4. Zero-effective amounts: LSR 0x1234_5678 by 0 with carry_in=1 -> result unchanged, carry_out 1,
//     done at cycle 1. ROR 0x8000_0001 by 64 -> result 0x8000_0001, carry_out 1, done at cycle 1.
//  5. Flush in the 2nd SHIFT cycle of LSL-by-33 -> back in IDLE next cycle, no done pulse, old result
//     held. rst asserted mid-op -> all outputs 0.
//  6. Start held high through a 6-cycle op -> exactly one done. stall=1 from the start cycle until
//     DONE inclusive; busy=0 in IDLE. A start arriving in the DONE cycle is accepted the following cycle.

Source files
------------

// File: rtl/arm_defs.sv
// Shared EXE-stage definitions: shift-type codes, sequencer state encoding and
// the helper that turns an Rs[7:0] amount into an effective shift count.
package arm_defs;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } seq_state_t;

    localparam int REM_W = 6;  // holds 0..33

    // Effective count: LSL/LSR saturate at 33 (result 0, carry 0), ASR at 32
    // (all sign bits), ROR only looks at the low five bits.
    function automatic logic [REM_W-1:0] rem_for(input shift_t t, input logic [7:0] amt);
        logic [REM_W-1:0] r;
        r = {1'b0, amt[4:0]};
        case (t)
            SH_LSL, SH_LSR: r = (amt > 8'd33) ? 6'd33 : amt[5:0];
            SH_ASR:         r = (amt > 8'd32) ? 6'd32 : amt[5:0];
            default:        r = {1'b0, amt[4:0]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts by k (0..STEP) and reports the
// last bit shifted out. k = 0 passes the value through with carry 0.
module shift_step
    import arm_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int K_W    = 4
) (
    input  logic [DATA_W-1:0]   value_i,
    input  shift_t              type_i,
    input  logic [K_W-1:0]      k_i,
    output logic [DATA_W-1:0]   value_o,
    output logic                carry_o
);

    logic [DATA_W:0]     ext;
    logic [2*DATA_W-1:0] rot;

    // The extra guard bit of ext catches the last bit shifted out.
    always_comb begin
        // NOTE: every output and temporary gets a default first so no path
        // through the case leaves a latch behind.
        ext     = '0;
        rot     = '0;
        value_o = value_i;
        carry_o = 1'b0;
        case (type_i)
            SH_LSL: begin
                ext     = {1'b0, value_i} << k_i;
                value_o = ext[DATA_W-1:0];
                carry_o = ext[DATA_W];
            end
            SH_LSR: begin
                ext     = {value_i, 1'b0} >> k_i;
                value_o = ext[DATA_W:1];
                carry_o = ext[0];
            end
            SH_ASR: begin
                ext     = $signed({value_i, 1'b0}) >>> k_i;
                value_o = ext[DATA_W:1];
                carry_o = ext[0];
            end
            SH_ROR: begin
                rot     = {value_i, value_i} >> k_i;
                value_o = rot[DATA_W-1:0];
                carry_o = (k_i != '0) ? rot[DATA_W-1] : 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Multi-cycle controller for register-specified shifts: latches Rm, type and
// the Rs amount, iterates shift_step, and stalls the pipeline until done.
module shift_reg_sequencer
    import arm_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          shift_type,
    input  logic [DATA_W-1:0]   val_rm,
    input  logic [7:0]          rs_amount,
    input  logic                carry_in,
    input  logic                flush,
    output logic                busy,
    output logic                stall,
    output logic                done,
    output logic [DATA_W-1:0]   result,
    output logic                carry_out
);

    localparam int K_W = $clog2(STEP + 1);

    seq_state_t         state_q, state_d;
    logic [DATA_W-1:0]  val_q, val_d;
    shift_t             type_q, type_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               carry_q, carry_d;

    logic [REM_W-1:0]   k_full;
    logic [K_W-1:0]     k;
    logic [DATA_W-1:0]  step_val;
    logic               step_carry;
    shift_t             req_type;

    assign req_type = shift_t'(shift_type);
    assign k_full   = (rem_q > REM_W'(STEP)) ? REM_W'(STEP) : rem_q;
    assign k        = K_W'(k_full);

    shift_step #(
        .DATA_W (DATA_W),
        .K_W    (K_W)
    ) u_step (
        .value_i (val_q),
        .type_i  (type_q),
        .k_i     (k),
        .value_o (step_val),
        .carry_o (step_carry)
    );

    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        type_d   = type_q;
        rem_d    = rem_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (rs_amount == 8'd0) begin
                        result_d = val_rm;
                        carry_d  = carry_in;
                        state_d  = S_DONE;
                    end else if (req_type == SH_ROR && rs_amount[4:0] == 5'd0) begin
                        result_d = val_rm;
                        carry_d  = val_rm[DATA_W-1];
                        state_d  = S_DONE;
                    end else begin
                        val_d   = val_rm;
                        type_d  = req_type;
                        rem_d   = rem_for(req_type, rs_amount);
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                val_d = step_val;
                rem_d = rem_q - k_full;
                if (rem_d == '0) begin
                    result_d = step_val;
                    carry_d  = step_carry;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Flush overrides everything, including a completing step and an
        // accept in IDLE; the published result stays untouched.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            carry_d  = carry_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            val_q    <= '0;
            type_q   <= SH_LSL;
            rem_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            type_q   <= type_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign stall     = busy || (start && state_q == S_IDLE);
    assign done      = (state_q == S_DONE) && !flush && !rst;
    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer: a vector table of single operations
// plus hand-written flush, reset and held-start sequences.
module tb_shift_reg_sequencer;
    import arm_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  shift_type;
    logic [31:0] val_rm;
    logic [7:0]  rs_amount;
    logic        carry_in;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        carry_out;

    always #5 clk = ~clk;

    shift_reg_sequencer #(.DATA_W(32), .STEP(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .shift_type (shift_type),
        .val_rm     (val_rm),
        .rs_amount  (rs_amount),
        .carry_in   (carry_in),
        .flush      (flush),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out)
    );

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] val;
        logic [7:0]  amt;
        logic        ci;
        logic [31:0] exp_res;
        logic        exp_cy;
        int          exp_lat;
    } vec_t;

    vec_t vecs[15];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [1:0] t, input logic [31:0] v, input logic [7:0] a,
                            input logic c);
        shift_type = t;
        val_rm     = v;
        rs_amount  = a;
        carry_in   = c;
        start      = 1'b1;
    endtask

    // Called at a falling edge with the DUT idle; cycle 0 is the accept cycle.
    task automatic run_vec(input vec_t x, input int idx);
        int lat;
        lat = 0;
        drive_op(x.typ, x.val, x.amt, x.ci);
        #1;
        check($sformatf("v%0d stall_on_start", idx), 32'(stall), 32'd1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(x.exp_lat));
        check($sformatf("v%0d result", idx), result, x.exp_res);
        check($sformatf("v%0d carry_out", idx), 32'(carry_out), 32'(x.exp_cy));
        @(negedge clk);
        check($sformatf("v%0d idle_after_done", idx), {30'd0, busy, done}, 32'd0);
    endtask

    int   nd;
    logic seen;

    initial begin
        vecs[0]  = '{SH_LSL, 32'h0000_0001, 8'd4,   1'b1, 32'h0000_0010, 1'b0, 2};
        vecs[1]  = '{SH_LSR, 32'h8000_0000, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 5};
        vecs[2]  = '{SH_LSL, 32'hFFFF_FFFF, 8'd40,  1'b0, 32'h0000_0000, 1'b0, 6};
        vecs[3]  = '{SH_ASR, 32'h8000_0000, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 5};
        vecs[4]  = '{SH_ROR, 32'h0000_00F0, 8'd36,  1'b0, 32'h0000_000F, 1'b0, 2};
        vecs[5]  = '{SH_LSR, 32'h1234_5678, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 1};
        vecs[6]  = '{SH_ROR, 32'h8000_0001, 8'd64,  1'b0, 32'h8000_0001, 1'b1, 1};
        vecs[7]  = '{SH_LSL, 32'hFFFF_FFFF, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 5};
        vecs[8]  = '{SH_LSR, 32'h1234_5678, 8'd12,  1'b1, 32'h0001_2345, 1'b0, 3};
        vecs[9]  = '{SH_ASR, 32'h8000_0000, 8'd31,  1'b0, 32'hFFFF_FFFF, 1'b0, 5};
        vecs[10] = '{SH_ROR, 32'h0000_0001, 8'd1,   1'b0, 32'h8000_0000, 1'b1, 2};
        vecs[11] = '{SH_ASR, 32'h7FFF_FFFF, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 5};
        vecs[12] = '{SH_LSL, 32'h8000_0000, 8'd1,   1'b0, 32'h0000_0000, 1'b1, 2};
        vecs[13] = '{SH_ROR, 32'h1234_5678, 8'd8,   1'b1, 32'h7812_3456, 1'b0, 2};
        vecs[14] = '{SH_LSR, 32'h0000_00FF, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 6};

        rst        = 1'b1;
        start      = 1'b0;
        flush      = 1'b0;
        shift_type = SH_LSL;
        val_rm     = '0;
        rs_amount  = '0;
        carry_in   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset result", result, 32'd0);
        check("reset carry_out", 32'(carry_out), 32'd0);

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Known result before the flush: LSL 3 by 1 -> 6, carry 0.
        run_vec('{SH_LSL, 32'h0000_0003, 8'd1, 1'b0, 32'h0000_0006, 1'b0, 2}, 15);

        // Flush during the 2nd SHIFT cycle of LSL by 33.
        drive_op(SH_LSL, 32'hFFFF_FFFF, 8'd33, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check("flush busy_shift1", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush done_suppressed", 32'(done), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush idle_next", {30'd0, busy, done}, 32'd0);
        check("flush result_held", result, 32'h0000_0006);
        check("flush carry_held", 32'(carry_out), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("flush no_late_done", 32'(seen), 32'd0);

        // start and flush together in IDLE: nothing is accepted.
        drive_op(SH_LSL, 32'h0000_0001, 8'd4, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_idle busy", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("flush_idle no_done", 32'(seen), 32'd0);
        check("flush_idle result", result, 32'h0000_0006);

        // Synchronous reset in the middle of LSR by 32.
        drive_op(SH_LSR, 32'h8000_0000, 8'd32, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset outputs", {busy, done, carry_out, result[28:0]}, 32'd0);
        check("midreset result", result, 32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("midreset no_done", 32'(seen), 32'd0);

        // start held through a 6-cycle op, then a new op offered in the DONE cycle.
        drive_op(SH_LSL, 32'hFFFF_FFFF, 8'd40, 1'b1);
        #1;
        check("held stall_c0", 32'(stall), 32'd1);
        nd = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("held stall_c%0d", c), 32'(stall), 32'd1);
            if (done) nd++;
        end
        check("held done_at_c6", 32'(done), 32'd1);
        check("held single_done", 32'(nd), 32'd1);
        check("held result", result, 32'd0);
        drive_op(SH_LSL, 32'h0000_0001, 8'd4, 1'b1);
        @(negedge clk);
        check("held c7 busy", 32'(busy), 32'd0);
        check("held c7 stall", 32'(stall), 32'd1);
        check("held c7 done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("held c8 busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("held c9 done", 32'(done), 32'd1);
        check("held c9 result", result, 32'h0000_0010);
        check("held c9 carry", 32'(carry_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
